// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of the load-use bubbles inserted.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] rs1_data_id,
    input  logic [XLEN-1:0] rs2_data_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [4:0]      rs_id,
    input  logic [4:0]      rt_id,
    input  logic [4:0]      rd_id,
    input  logic            uses_rs_id,
    input  logic            uses_rt_id,
    input  logic [9:0]      ctrl_id,
    input  logic            flush_ex,
    input  logic            hold_ex,
    output logic            valid_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs_ex,
    output logic [4:0]      rt_ex,
    output logic [4:0]      rd_ex,
    output logic [9:0]      ctrl_ex,
    output logic            stall_if,
    output logic [15:0]     bubble_cnt
);

    logic hz;
    logic rs_match;
    logic rt_match;

    // Only memread matters: a load to x0 never stalls because rd_ex must be nonzero.
    always_comb begin
        rs_match = uses_rs_id && (rd_ex == rs_id);
        rt_match = uses_rt_id && (rd_ex == rt_id);
        hz       = valid_ex && ctrl_ex[1] && valid_id && (rd_ex != 5'd0) && (rs_match || rt_match);
    end

    // A flush redirects fetch, so it overrides any stall request.
    always_comb begin
        stall_if = 1'b0;
        if (!flush_ex && (hold_ex || hz)) begin
            stall_if = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
            ctrl_ex     <= '0;
            bubble_cnt  <= '0;
        end else if (hold_ex && !flush_ex) begin
            valid_ex    <= valid_ex;
        end else if (flush_ex || hz || !valid_id) begin
            // Bubble pattern: all fields zero so x0 never matches in forwarding.
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
            ctrl_ex     <= '0;
            if (!flush_ex && hz && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end else begin
            valid_ex    <= 1'b1;
            pc_ex       <= pc_id;
            rs1_data_ex <= rs1_data_id;
            rs2_data_ex <= rs2_data_id;
            imm_ex      <= imm_id;
            rs_ex       <= rs_id;
            rt_ex       <= rt_id;
            rd_ex       <= rd_id;
            ctrl_ex     <= ctrl_id;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table-driven vectors with a scoreboard
// queue of expected EX contents, plus hold, reset and saturation sequences.
module tb_id_ex_stage;

    localparam logic [9:0] LW  = 10'b0000101011;
    localparam logic [9:0] ADD = 10'b0010000001;

    typedef enum logic [1:0] {K_LOAD, K_BUBBLE, K_KEEP} kind_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        urs;
        logic        urt;
        logic [9:0]  ctrl;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        kind_t       kind;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [9:0]  ctrl;
        logic [15:0] cnt;
    } ex_rec_t;

    logic        clk, rst_n;
    logic        valid_id, uses_rs_id, uses_rt_id, flush_ex, hold_ex;
    logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic [9:0]  ctrl_id;
    logic        valid_ex, stall_if;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic [9:0]  ctrl_ex;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;
    ex_rec_t m_ex;
    ex_rec_t sb[$];
    vec_t    tbl[$];

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
        .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .ctrl_id(ctrl_id),
        .flush_ex(flush_ex), .hold_ex(hold_ex), .valid_ex(valid_ex), .pc_ex(pc_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .ctrl_ex(ctrl_ex),
        .stall_if(stall_if), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic urs, logic urt, logic [9:0] ctrl,
                                logic fl, logic hd, logic st, kind_t k, logic [15:0] c);
        vec_t r;
        r.valid = v; r.pc = pc; r.rs = rs; r.rt = rt; r.rd = rd; r.urs = urs; r.urt = urt;
        r.ctrl = ctrl; r.flush = fl; r.hold = hd; r.exp_stall = st; r.kind = k; r.exp_cnt = c;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        valid_id    = v.valid;
        pc_id       = v.pc;
        rs1_data_id = v.pc ^ 32'hA5A5_0000;
        rs2_data_id = v.pc + 32'h0000_1000;
        imm_id      = ~v.pc;
        rs_id       = v.rs;
        rt_id       = v.rt;
        rd_id       = v.rd;
        uses_rs_id  = v.urs;
        uses_rt_id  = v.urt;
        ctrl_id     = v.ctrl;
        flush_ex    = v.flush;
        hold_ex     = v.hold;
    endtask

    function automatic ex_rec_t expect_of(vec_t v, ex_rec_t prev);
        ex_rec_t r;
        r = prev;
        if (v.kind == K_LOAD) begin
            r.valid = 1'b1; r.pc = v.pc; r.rs1 = v.pc ^ 32'hA5A5_0000;
            r.rs2 = v.pc + 32'h0000_1000; r.imm = ~v.pc;
            r.rs = v.rs; r.rt = v.rt; r.rd = v.rd; r.ctrl = v.ctrl;
        end else if (v.kind == K_BUBBLE) begin
            r.valid = 1'b0; r.pc = '0; r.rs1 = '0; r.rs2 = '0; r.imm = '0;
            r.rs = '0; r.rt = '0; r.rd = '0; r.ctrl = '0;
        end
        r.cnt = v.exp_cnt;
        return r;
    endfunction

    task automatic compare_ex(string tag);
        ex_rec_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " valid_ex"}, 32'(valid_ex), 32'(e.valid));
        check({tag, " pc_ex"}, pc_ex, e.pc);
        check({tag, " rs1_data_ex"}, rs1_data_ex, e.rs1);
        check({tag, " rs2_data_ex"}, rs2_data_ex, e.rs2);
        check({tag, " imm_ex"}, imm_ex, e.imm);
        check({tag, " rs_ex"}, 32'(rs_ex), 32'(e.rs));
        check({tag, " rt_ex"}, 32'(rt_ex), 32'(e.rt));
        check({tag, " rd_ex"}, 32'(rd_ex), 32'(e.rd));
        check({tag, " ctrl_ex"}, 32'(ctrl_ex), 32'(e.ctrl));
        check({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(e.cnt));
    endtask

    // Called at a negedge: drive, check stall_if, push expectation, compare after the edge.
    task automatic step(vec_t v, string tag);
        drive(v);
        #1;
        check({tag, " stall_if"}, 32'(stall_if), 32'(v.exp_stall));
        m_ex = expect_of(v, m_ex);
        sb.push_back(m_ex);
        @(posedge clk);
        #1;
        compare_ex(tag);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_BUBBLE, 0));
        m_ex = expect_of(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, K_BUBBLE, 0), m_ex);
        #1;
        check("reset valid_ex", 32'(valid_ex), 0);
        check("reset pc_ex", pc_ex, 0);
        check("reset bubble_cnt", 32'(bubble_cnt), 0);
        check("reset stall_if", 32'(stall_if), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //            v  pc      rs rt rd urs urt ctrl fl hd st kind      cnt
        tbl.push_back(mk(1, 32'h100, 2, 0, 5, 1, 0, LW,  0, 0, 0, K_LOAD,   0)); // lw x5
        tbl.push_back(mk(1, 32'h104, 5, 7, 6, 1, 1, ADD, 0, 0, 1, K_BUBBLE, 1)); // load-use on rs
        tbl.push_back(mk(1, 32'h104, 5, 7, 6, 1, 1, ADD, 0, 0, 0, K_LOAD,   1)); // add enters EX
        tbl.push_back(mk(1, 32'h108, 6, 0, 9, 1, 0, LW,  0, 0, 0, K_LOAD,   1)); // rd match, not a load
        tbl.push_back(mk(1, 32'h10C, 1, 9, 3, 1, 1, ADD, 0, 0, 1, K_BUBBLE, 2)); // load-use on rt
        tbl.push_back(mk(1, 32'h10C, 1, 9, 3, 1, 1, ADD, 0, 0, 0, K_LOAD,   2));
        tbl.push_back(mk(1, 32'h110, 3, 0, 0, 1, 0, LW,  0, 0, 0, K_LOAD,   2)); // lw x0
        tbl.push_back(mk(1, 32'h114, 0, 0, 4, 1, 1, ADD, 0, 0, 0, K_LOAD,   2)); // x0 never stalls
        tbl.push_back(mk(1, 32'h118, 3, 0, 5, 1, 0, LW,  0, 0, 0, K_LOAD,   2));
        tbl.push_back(mk(1, 32'h11C, 5, 8, 7, 0, 1, ADD, 0, 0, 0, K_LOAD,   2)); // rs=5 but unused
        tbl.push_back(mk(1, 32'h120, 3, 0, 5, 1, 0, LW,  0, 0, 0, K_LOAD,   2));
        tbl.push_back(mk(1, 32'h124, 5, 0, 7, 1, 0, ADD, 1, 0, 0, K_BUBBLE, 2)); // hz + flush
        tbl.push_back(mk(1, 32'h128, 3, 0, 5, 1, 0, LW,  0, 0, 0, K_LOAD,   2));
        tbl.push_back(mk(1, 32'h12C, 5, 0, 7, 1, 0, ADD, 0, 1, 1, K_KEEP,   2)); // hold beats hz
        tbl.push_back(mk(1, 32'h12C, 5, 0, 7, 1, 0, ADD, 0, 0, 1, K_BUBBLE, 3));
        tbl.push_back(mk(0, 32'h130, 4, 4, 4, 1, 1, ADD, 0, 0, 0, K_BUBBLE, 3)); // invalid ID
        tbl.push_back(mk(1, 32'h134, 1, 2, 3, 1, 1, ADD, 1, 1, 0, K_BUBBLE, 3)); // flush beats hold
        tbl.push_back(mk(1, 32'h138, 3, 0, 5, 1, 0, LW,  0, 0, 0, K_LOAD,   3));
        tbl.push_back(mk(0, 32'h13C, 5, 0, 7, 1, 0, ADD, 0, 0, 0, K_BUBBLE, 3)); // invalid ID no hz
        tbl.push_back(mk(1, 32'h040, 1, 2, 8, 1, 1, ADD, 0, 0, 0, K_LOAD,   3));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Hold for three cycles with pc_ex = 0x40, then release.
        for (int i = 0; i < 3; i++)
            step(mk(1, 32'h200, 1, 2, 9, 1, 1, ADD, 0, 1, 1, K_KEEP, 3), $sformatf("hold%0d", i));
        check("hold pc_ex", pc_ex, 32'h0000_0040);
        step(mk(1, 32'h200, 1, 2, 9, 1, 1, ADD, 0, 0, 0, K_LOAD, 3), "hold_release");

        // Reset asserted between edges during a load-use stall.
        step(mk(1, 32'h300, 3, 0, 5, 1, 0, LW, 0, 0, 0, K_LOAD, 3), "rst_lw");
        v = mk(1, 32'h304, 5, 0, 6, 1, 0, ADD, 0, 0, 1, K_LOAD, 0);
        drive(v);
        #1;
        check("rst stall_if before", 32'(stall_if), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst async valid_ex", 32'(valid_ex), 0);
        check("rst async pc_ex", pc_ex, 0);
        check("rst async rd_ex", 32'(rd_ex), 0);
        check("rst async ctrl_ex", 32'(ctrl_ex), 0);
        check("rst async bubble_cnt", 32'(bubble_cnt), 0);
        check("rst async stall_if", 32'(stall_if), 0);
        #1 rst_n = 1'b1;
        m_ex = expect_of(v, m_ex);
        sb.push_back(m_ex);
        @(posedge clk);
        #1;
        compare_ex("rst_release");
        @(negedge clk);

        // Saturation: preset the counter near its limit, then keep producing hazards.
        dut.bubble_cnt = 16'hFFFD;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] c;
            c = (i < 1) ? 16'hFFFD : (i < 3) ? 16'hFFFE : 16'hFFFF;
            step(mk(1, 32'h400, 5, 0, 5, 1, 0, LW, 0, 0, i[0],
                    i[0] ? K_BUBBLE : K_LOAD, c), $sformatf("sat%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the PC, operand and immediate datapaths.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 valid_id  in  1  SHALL mark the IF/ID register as holding a live instruction.
REQ-005 pc_id  in  XLEN  SHALL carry the ID-stage PC.
REQ-006 rs1_data_id  in  XLEN  SHALL carry register-file read port 1.
REQ-007 rs2_data_id  in  XLEN  SHALL carry register-file read port 2.
REQ-008 imm_id  in  XLEN  SHALL carry the sign-extended immediate.
REQ-009 rs_id, rt_id, rd_id  in  5 each  SHALL carry the source and destination register numbers.
REQ-010 uses_rs_id, uses_rt_id  in  1 each  SHALL flag whether the ID instruction actually reads rs/rt.
REQ-011 ctrl_id  in  10  SHALL carry control: [9:6] alu_op, [5] alusrc, [4] branch, [3] memtoreg, [2] memwrite, [1] memread, [0] regwrite.
REQ-012 flush_ex  in  1  SHALL signal a taken branch/jump resolved in EX.
REQ-013 hold_ex  in  1  SHALL freeze the pipeline from EX onward (downstream busy).
REQ-014 valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs_ex, rt_ex, rd_ex, ctrl_ex  out  (widths of ID counterparts)  SHALL be the registered ID/EX contents; rs_ex/rt_ex feed the forwarding unit.
REQ-015 stall_if  out  1  SHALL, when 1, hold the PC and the IF/ID register.
REQ-016 bubble_cnt  out  16  SHALL count load-use bubbles inserted since reset.

Function
REQ-017 Load-use hazard (combinational): hz = valid_ex & ctrl_ex[1] & valid_id & (rd_ex != 0) & ((uses_rs_id & rd_ex == rs_id) | (uses_rt_id & rd_ex == rt_id)).
REQ-018 Per-edge priority SHALL be: flush_ex > hold_ex > hz > normal load.
REQ-019 flush_ex=1: next state SHALL be a bubble; stall_if SHALL be 0 (redirect wins); bubble_cnt unchanged.
REQ-020 hold_ex=1 (no flush): all ID/EX registers SHALL keep their values; stall_if SHALL be 1; bubble_cnt unchanged.
REQ-021 hz=1 (no flush, no hold): next state SHALL be a bubble; stall_if SHALL be 1; bubble_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-022 Normal: every *_ex register SHALL load its *_id counterpart; valid_ex <= valid_id; stall_if = 0.
REQ-023 Bubble SHALL mean valid_ex=0 and pc/data/imm/rs/rt/rd/ctrl all 0, so rd_ex/rs_ex/rt_ex = x0 never match in forwarding.
REQ-024 Normal load with valid_id=0 SHALL also write the bubble pattern rather than stale ID fields.
REQ-025 Latency ID->EX SHALL be exactly 1 cycle; a load-use stall SHALL last exactly 1 cycle because the bubble clears hz on the next edge.
REQ-026 stall_if SHALL be combinational from hz, hold_ex, flush_ex and current state; no other output is combinational.
REQ-027 hz SHALL ignore regwrite and consider only memread, so a load to x0 (rd_ex=0) never stalls.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) force the bubble pattern on all *_ex outputs and bubble_cnt=0; stall_if then evaluates to 0 unless hold_ex=1.
REQ-029 Reset deasserted mid-stall SHALL resume with no pending stall; first edge after release performs a normal load.

Verification
REQ-030 Load x5 (ctrl_ex[1]=1, rd_ex=5) then ID add with rs_id=5, uses_rs_id=1 -> stall_if=1 one cycle, valid_ex=0 next edge, bubble_cnt 0->1, add enters EX on following edge.
REQ-031 Same but rs_id=5 with uses_rs_id=0, or rd_ex=0 -> no stall, bubble_cnt stays 0.
REQ-032 hz=1 and flush_ex=1 same cycle -> bubble, stall_if=0, bubble_cnt unchanged.
REQ-033 hold_ex=1 for 3 cycles with pc_ex=32'h0000_0040 -> pc_ex stays 32'h0000_0040, stall_if=1 throughout, then ID contents load on release.
REQ-034 Force bubble_cnt to 16'hFFFF via 65535 hazards then one more -> stays 16'hFFFF.
REQ-035 Assert rst_n=0 between edges during a stall -> outputs zero immediately without clk; after release next edge loads ID normally.
